// File: rtl/core_pkg.sv
// Shared run-control definitions: hart state encoding and drain-counter sizing.
// Pure declarations; no logic of its own.
package core_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  typedef enum logic [1:0] {
    HS_IDLE   = ST_IDLE,
    HS_RUN    = ST_RUN,
    HS_DRAIN  = ST_DRAIN,
    HS_HALTED = ST_HALTED
  } hart_state_t;

  function automatic int cnt_width(input int drain_cycles);
    int w;
    w = $clog2(drain_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/core_hart_fsm.sv
// One hart's run state and drain countdown; outputs decode registered state (1-cycle latency).
// A stalled hart freezes state and counter and drops that cycle's requests.
module core_hart_fsm
  import core_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = cnt_width(DRAIN_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic halt_req,
  input  logic resume,
  input  logic stall,
  output logic active,
  output logic halted,
  output logic fetch_en
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (DRAIN_CYCLES == 0) ? '0 : CNT_W'(DRAIN_CYCLES - 1);

  hart_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HS_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!stall) begin
      case (state)
        HS_IDLE: begin
          if (start) state_nxt = HS_RUN;
        end
        HS_RUN: begin
          // halt_req outranks start/resume arriving in the same cycle
          if (halt_req) begin
            if (DRAIN_CYCLES == 0) begin
              state_nxt = HS_HALTED;
            end else begin
              state_nxt = HS_DRAIN;
              cnt_nxt   = CNT_LOAD;
            end
          end
        end
        HS_DRAIN: begin
          if (cnt == '0) state_nxt = HS_HALTED;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
        HS_HALTED: begin
          if (resume || start) state_nxt = HS_RUN;
        end
        default: state_nxt = HS_IDLE;
      endcase
    end
  end

  assign active   = (state == HS_RUN) || (state == HS_DRAIN);
  assign halted   = (state == HS_HALTED);
  assign fetch_en = (state == HS_RUN);

endmodule

// File: rtl/core_run_ctrl.sv
// Multi-hart run control with round-robin fetch grant; status outputs lag events by one cycle, grant is combinational.
// Stalled harts are excluded from arbitration and hold their run state.
module core_run_ctrl
  import core_pkg::*;
#(
  parameter int NHART        = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NHART-1:0] start,
  input  logic [NHART-1:0] halt_req,
  input  logic [NHART-1:0] resume,
  input  logic [NHART-1:0] stall,
  output logic [NHART-1:0] active,
  output logic [NHART-1:0] halted,
  output logic [NHART-1:0] fetch_en,
  output logic [NHART-1:0] grant
);

  localparam int CNT_W = cnt_width(DRAIN_CYCLES);
  localparam int PTR_W = (NHART > 1) ? $clog2(NHART) : 1;

  for (genvar i = 0; i < NHART; i++) begin : g_hart
    core_hart_fsm #(
      .DRAIN_CYCLES(DRAIN_CYCLES),
      .CNT_W       (CNT_W)
    ) u_hart (
      .clk     (clk),
      .rst     (rst),
      .start   (start[i]),
      .halt_req(halt_req[i]),
      .resume  (resume[i]),
      .stall   (stall[i]),
      .active  (active[i]),
      .halted  (halted[i]),
      .fetch_en(fetch_en[i])
    );
  end

  logic [NHART-1:0] cand;
  logic [PTR_W-1:0] rr_ptr, rr_nxt;
  logic             found;
  int               gidx;

  assign cand = fetch_en & ~stall;

  // Two passes give a cyclic search: indices at/after rr_ptr first, then the wrap.
  always_comb begin
    grant  = '0;
    rr_nxt = rr_ptr;
    found  = 1'b0;
    gidx   = 0;
    for (int i = 0; i < NHART; i++) begin
      if (!found && cand[i] && (i >= int'(rr_ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        gidx     = i;
      end
    end
    for (int i = 0; i < NHART; i++) begin
      if (!found && cand[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        gidx     = i;
      end
    end
    if (found) rr_nxt = PTR_W'((gidx + 1) % NHART);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else     rr_ptr <= rr_nxt;
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed vector table for a 2-hart, 4-cycle-drain controller, plus a hand sequence
// against a zero-drain instance. Inputs change on the falling edge; outputs are checked 1ns later.
module tb_core_run_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst0 = 1'b1;
  logic [1:0] start = '0, halt_req = '0, resume = '0, stall = '0;
  logic [1:0] active, halted, fetch_en, grant;
  logic [1:0] active0, halted0, fetch_en0, grant0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_run_ctrl #(.NHART(2), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .resume(resume),
    .stall(stall), .active(active), .halted(halted), .fetch_en(fetch_en), .grant(grant)
  );

  core_run_ctrl #(.NHART(2), .DRAIN_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .start(start), .halt_req(halt_req), .resume(resume),
    .stall(stall), .active(active0), .halted(halted0), .fetch_en(fetch_en0), .grant(grant0)
  );

  typedef struct {
    logic       r;
    logic [1:0] st, hr, rs, sl;
    logic [1:0] act, hlt, fe, gnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [1:0] st, hr, rs, sl,
                     input logic [1:0] act, hlt, fe, gnt);
    vec_t v;
    v.r = r; v.st = st; v.hr = hr; v.rs = rs; v.sl = sl;
    v.act = act; v.hlt = hlt; v.fe = fe; v.gnt = gnt;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got act=%b hlt=%b fe=%b gnt=%b, want act=%b hlt=%b fe=%b gnt=%b",
               nm, idx, got[7:6], got[5:4], got[3:2], got[1:0],
               exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] st, hr, rs, sl);
    rst = r; start = st; halt_req = hr; resume = rs; stall = sl;
  endtask

  initial begin
    //   rst start halt resume stall | active halted fetch_en grant
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // 0 after reset
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // 1 start hart0
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01); // 2
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01); // 3
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01); // 4 start hart1
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10); // 5 round robin
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b01); // 6
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10); // 7
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b01); // 8
    add(0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01); // 9 hart1 stalled
    add(0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01); // 10
    add(0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01); // 11
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10); // 12
    add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b01); // 13 halt hart0
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10); // 14 drain 1
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10); // 15 drain 2
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10); // 16 drain 3
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10); // 17 drain 4
    add(0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10); // 18 halted; resume beats halt
    add(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b01); // 19 run; all three -> drain
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10); // 20 drain 1
    add(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b10); // 21 stalled
    add(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b10); // 22 stalled
    add(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b10); // 23 stalled
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10); // 24 drain 2
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10); // 25 drain 3
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10); // 26 drain 4
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10); // 27 halted
    add(0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10); // 28 halt hart1
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00); // 29 reset mid-drain
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // 30 all clear

    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].r, tv[i].st, tv[i].hr, tv[i].rs, tv[i].sl);
      #1;
      chk("table", i, {active, halted, fetch_en, grant},
          {tv[i].act, tv[i].hlt, tv[i].fe, tv[i].gnt});
    end

    // Zero-length drain on dut0, with dut running the same stimulus as reference.
    @(negedge clk);
    drive(1, 2'b00, 2'b00, 2'b00, 2'b00);
    rst0 = 1'b1;
    @(negedge clk);
    drive(0, 2'b00, 2'b00, 2'b00, 2'b00);
    rst0 = 1'b0;
    #1;
    chk("z_reset", 0, {active0, halted0, fetch_en0, grant0}, 8'b00_00_00_00);
    chk("d_reset", 0, {active, halted, fetch_en, grant}, 8'b00_00_00_00);
    @(negedge clk);
    drive(0, 2'b01, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    drive(0, 2'b00, 2'b01, 2'b00, 2'b00);
    #1;
    chk("z_run", 0, {active0, halted0, fetch_en0, grant0}, 8'b01_00_01_01);
    @(negedge clk);
    drive(0, 2'b00, 2'b00, 2'b00, 2'b00);
    #1;
    chk("z_halted", 0, {active0, halted0, fetch_en0, grant0}, 8'b00_01_00_00);
    chk("d_drain", 0, {active, halted, fetch_en, grant}, 8'b01_00_00_00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      chk("d_drain", k, {active, halted, fetch_en, grant}, 8'b01_00_00_00);
    end
    @(negedge clk);
    #1;
    chk("d_halted", 0, {active, halted, fetch_en, grant}, 8'b00_01_00_00);
    chk("z_hold", 0, {active0, halted0, fetch_en0, grant0}, 8'b00_01_00_00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
